// File: rtl/wb_regfile_pkg.sv
// Shared encodings and constants for the write-back stage register file.
// Imported by wb_mux and wb_regfile.
package wb_regfile_pkg;

    localparam int unsigned NREG    = 32;
    localparam int unsigned REG_AW  = 5;
    localparam int unsigned XLEN    = 32;

    typedef logic [XLEN-1:0]   word_t;
    typedef logic [REG_AW-1:0] reg_idx_t;

    // MemtoReg_wb write-data select
    localparam logic [1:0] MTR_ALU  = 2'b00;
    localparam logic [1:0] MTR_MEM  = 2'b01;
    localparam logic [1:0] MTR_LINK = 2'b10;
    localparam logic [1:0] MTR_RSVD = 2'b11;

    // LdExt_wb load extension; unlisted codes behave as a word load
    localparam logic [2:0] LDX_WORD = 3'b000;
    localparam logic [2:0] LDX_LB   = 3'b001;
    localparam logic [2:0] LDX_LBU  = 3'b010;
    localparam logic [2:0] LDX_LH   = 3'b011;
    localparam logic [2:0] LDX_LHU  = 3'b100;

    // Link value is the address two instructions past the retiring one
    localparam word_t LINK_OFFSET = 32'd8;

    function automatic word_t ext_byte(input logic [7:0] b, input logic sgn);
        return {{24{sgn & b[7]}}, b};
    endfunction

    function automatic word_t ext_half(input logic [15:0] h, input logic sgn);
        return {{16{sgn & h[15]}}, h};
    endfunction

endpackage

// File: rtl/wb_mux.sv
// Write-back data path: sub-word load extraction/extension and final write-data select.
// Purely combinational.
module wb_mux (
    input  logic [1:0]  MemtoReg_wb,
    input  logic [2:0]  LdExt_wb,
    input  logic [31:0] dmout_wb,
    input  logic [31:0] aluout_wb,
    input  logic [31:0] pc_wb,
    output logic [31:0] wd_wb
);
    import wb_regfile_pkg::*;

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    word_t       load_data;

    always_comb begin
        byte_sel = dmout_wb[7:0];
        unique case (aluout_wb[1:0])
            2'd0: byte_sel = dmout_wb[7:0];
            2'd1: byte_sel = dmout_wb[15:8];
            2'd2: byte_sel = dmout_wb[23:16];
            2'd3: byte_sel = dmout_wb[31:24];
            default: byte_sel = dmout_wb[7:0];
        endcase
        // Halfword offset comes from bit 1 alone; bit 0 is ignored
        half_sel = aluout_wb[1] ? dmout_wb[31:16] : dmout_wb[15:0];
    end

    always_comb begin
        load_data = dmout_wb;
        case (LdExt_wb)
            LDX_LB:  load_data = ext_byte(byte_sel, 1'b1);
            LDX_LBU: load_data = ext_byte(byte_sel, 1'b0);
            LDX_LH:  load_data = ext_half(half_sel, 1'b1);
            LDX_LHU: load_data = ext_half(half_sel, 1'b0);
            default: load_data = dmout_wb;
        endcase
    end

    always_comb begin
        wd_wb = aluout_wb;
        unique case (MemtoReg_wb)
            MTR_ALU:  wd_wb = aluout_wb;
            MTR_MEM:  wd_wb = load_data;
            MTR_LINK: wd_wb = pc_wb + LINK_OFFSET;
            MTR_RSVD: wd_wb = aluout_wb;
            default:  wd_wb = aluout_wb;
        endcase
    end

endmodule

// File: rtl/wb_regfile.sv
// Architectural register file with write-through bypass and a committed-write counter.
// Register 0 is hard-wired to zero; reset clears the array asynchronously.
module wb_regfile #(
    parameter int unsigned NREG = wb_regfile_pkg::NREG
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RegWrite_wb,
    input  logic [1:0]  MemtoReg_wb,
    input  logic [2:0]  LdExt_wb,
    input  logic [31:0] dmout_wb,
    input  logic [31:0] aluout_wb,
    input  logic [31:0] pc_wb,
    input  logic [4:0]  a3_wb,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    output logic [31:0] wd_wb,
    output logic [31:0] retire_cnt
);
    import wb_regfile_pkg::*;

    word_t regs_q [1:NREG-1];
    word_t regs_d [1:NREG-1];
    word_t retire_cnt_q, retire_cnt_d;

    logic  wr_en;
    word_t arr_rd1, arr_rd2;

    wb_mux u_wb_mux (
        .MemtoReg_wb (MemtoReg_wb),
        .LdExt_wb    (LdExt_wb),
        .dmout_wb    (dmout_wb),
        .aluout_wb   (aluout_wb),
        .pc_wb       (pc_wb),
        .wd_wb       (wd_wb)
    );

    assign wr_en = RegWrite_wb && (a3_wb != '0) && ({27'd0, a3_wb} < NREG);

    always_comb begin
        arr_rd1 = '0;
        arr_rd2 = '0;
        for (int i = 1; i < int'(NREG); i++) begin
            if (ra1 == 5'(i)) arr_rd1 = regs_q[i];
            if (ra2 == 5'(i)) arr_rd2 = regs_q[i];
        end
    end

    // Bypass is gated by rst_n so a write that cannot commit is never forwarded
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (rst_n) begin
            if (ra1 != '0) rd1 = (wr_en && (ra1 == a3_wb)) ? wd_wb : arr_rd1;
            if (ra2 != '0) rd2 = (wr_en && (ra2 == a3_wb)) ? wd_wb : arr_rd2;
        end
    end

    always_comb begin
        regs_d = regs_q;
        retire_cnt_d = retire_cnt_q;
        if (wr_en) begin
            for (int i = 1; i < int'(NREG); i++) begin
                if (a3_wb == 5'(i)) regs_d[i] = wd_wb;
            end
            retire_cnt_d = retire_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < int'(NREG); i++) regs_q[i] <= '0;
            retire_cnt_q <= '0;
        end else begin
            regs_q       <= regs_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: directed scenarios plus randomized traffic against a
// behavioural model; expectations are queued at stimulus time and checked at negedge.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        RegWrite_wb;
    logic [1:0]  MemtoReg_wb;
    logic [2:0]  LdExt_wb;
    logic [31:0] dmout_wb, aluout_wb, pc_wb;
    logic [4:0]  a3_wb, ra1, ra2;
    logic [31:0] rd1, rd2, wd_wb, retire_cnt;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .RegWrite_wb (RegWrite_wb),
        .MemtoReg_wb (MemtoReg_wb),
        .LdExt_wb    (LdExt_wb),
        .dmout_wb    (dmout_wb),
        .aluout_wb   (aluout_wb),
        .pc_wb       (pc_wb),
        .a3_wb       (a3_wb),
        .ra1         (ra1),
        .ra2         (ra2),
        .rd1         (rd1),
        .rd2         (rd2),
        .wd_wb       (wd_wb),
        .retire_cnt  (retire_cnt)
    );

    typedef struct {
        string       name;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] wd;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] mem_m [32];
    logic [31:0] cnt_m;
    int          n_checks = 0;
    int          n_fail   = 0;

    // Reference write-data value, computed arithmetically from the encodings
    function automatic logic [31:0] model_wd(input logic [1:0] mtr, input logic [2:0] ext,
                                             input logic [31:0] dm, input logic [31:0] alu,
                                             input logic [31:0] pc);
        logic [31:0] v;
        int          off;
        if (mtr == 2'd2) return pc + 32'd8;
        if (mtr != 2'd1) return alu;
        off = int'(alu[1:0]);
        case (ext)
            3'd1, 3'd2: begin
                v = (dm >> (8 * off)) & 32'h0000_00FF;
                if (ext == 3'd1 && v >= 32'd128) v = v - 32'd256;
            end
            3'd3, 3'd4: begin
                v = (dm >> (16 * (off / 2))) & 32'h0000_FFFF;
                if (ext == 3'd3 && v >= 32'd32768) v = v - 32'd65536;
            end
            default: v = dm;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] model_rd(input logic [4:0] ra, input logic we,
                                             input logic [4:0] a3, input logic [31:0] wd);
        if (!rst_n || ra == 5'd0) return 32'd0;
        if (we && a3 != 5'd0 && ra == a3) return wd;
        return mem_m[ra];
    endfunction

    task automatic set_rst(input logic v);
        rst_n = v;
        if (!v) begin
            foreach (mem_m[i]) mem_m[i] = 32'd0;
            cnt_m = 32'd0;
        end
    endtask

    // Entered shortly after a rising edge; returns shortly after the next one
    task automatic drive(input string nm, input logic we, input logic [1:0] mtr,
                         input logic [2:0] ext, input logic [31:0] dm, input logic [31:0] alu,
                         input logic [31:0] pc, input logic [4:0] a3, input logic [4:0] r1,
                         input logic [4:0] r2);
        exp_t        e;
        logic [31:0] wd;
        RegWrite_wb = we;  MemtoReg_wb = mtr;  LdExt_wb = ext;
        dmout_wb = dm;     aluout_wb = alu;    pc_wb = pc;
        a3_wb = a3;        ra1 = r1;           ra2 = r2;
        wd    = model_wd(mtr, ext, dm, alu, pc);
        e.name = nm;
        e.wd   = wd;
        e.rd1  = model_rd(r1, we, a3, wd);
        e.rd2  = model_rd(r2, we, a3, wd);
        e.cnt  = cnt_m;
        sb_q.push_back(e);
        @(posedge clk);
        if (rst_n && we && a3 != 5'd0) begin
            mem_m[a3] = wd;
            cnt_m     = cnt_m + 32'd1;
        end
        #1;
    endtask

    task automatic check(input string nm, input string fld, input logic [31:0] act,
                         input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s.%s: got 0x%08h, expected 0x%08h at %0t", nm, fld, act, req, $time);
        end
    endtask

    // Monitor: outputs are settled mid-cycle, so compare on the falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check(e.name, "rd1", rd1, e.rd1);
                check(e.name, "rd2", rd2, e.rd2);
                check(e.name, "wd_wb", wd_wb, e.wd);
                check(e.name, "retire_cnt", retire_cnt, e.cnt);
            end
        end
    end

    initial begin
        logic [4:0]  a3, r1, r2;
        logic [31:0] dm;
        set_rst(1'b0);
        RegWrite_wb = 0; MemtoReg_wb = 0; LdExt_wb = 0;
        dmout_wb = 0; aluout_wb = 0; pc_wb = 0; a3_wb = 0; ra1 = 0; ra2 = 0;
        @(posedge clk); #1;

        // In reset: all indices read 0 even with a live write and matching index
        for (int i = 0; i < 32; i++)
            drive("rst_hold", 1'b1, 2'd0, 3'd0, $urandom, $urandom, $urandom, 5'(i),
                  5'(i), 5'(31 - i));
        set_rst(1'b1);
        for (int i = 0; i < 32; i++)
            drive("post_rst", 1'b0, 2'd0, 3'd0, 0, 0, 0, 5'd0, 5'(i), 5'(31 - i));

        drive("byp_alu",  1'b1, 2'd0, 3'd0, 0, 32'h1234_5678, 0, 5'd5, 5'd5, 5'd5);
        drive("arr_alu",  1'b0, 2'd0, 3'd0, 0, 0, 0, 5'd0, 5'd5, 5'd5);

        dm = 32'h80FF_7F01;
        drive("lb3",  1'b1, 2'd1, 3'd1, dm, 32'd3, 0, 5'd10, 5'd10, 5'd0);
        drive("lbu3", 1'b1, 2'd1, 3'd2, dm, 32'd3, 0, 5'd11, 5'd11, 5'd10);
        drive("lh0",  1'b1, 2'd1, 3'd3, dm, 32'd0, 0, 5'd12, 5'd12, 5'd11);
        drive("lhu2", 1'b1, 2'd1, 3'd4, dm, 32'd2, 0, 5'd13, 5'd13, 5'd12);
        drive("ld_rd", 1'b0, 2'd0, 3'd0, 0, 0, 0, 5'd0, 5'd10, 5'd13);

        drive("link",    1'b1, 2'd2, 3'd0, 0, 32'h5555_AAAA, 32'h0000_3000, 5'd31, 5'd31, 5'd31);
        drive("link_rd", 1'b0, 2'd0, 3'd0, 0, 0, 0, 5'd0, 5'd31, 5'd0);
        drive("rsvd",    1'b1, 2'd3, 3'd1, dm, 32'hCAFE_0003, 0, 5'd3, 5'd3, 5'd3);

        drive("r0_wr", 1'b1, 2'd0, 3'd0, 0, 32'hDEAD_BEEF, 0, 5'd0, 5'd0, 5'd0);
        drive("r0_rd", 1'b0, 2'd0, 3'd0, 0, 0, 0, 5'd0, 5'd0, 5'd0);

        drive("r7_wr", 1'b1, 2'd0, 3'd0, 0, 32'h0000_00A5, 0, 5'd7, 5'd0, 5'd0);
        drive("r7_rd", 1'b0, 2'd0, 3'd0, 0, 0, 0, 5'd0, 5'd7, 5'd7);
        set_rst(1'b0);
        drive("r7_inrst", 1'b0, 2'd0, 3'd0, 0, 0, 0, 5'd0, 5'd7, 5'd7);
        set_rst(1'b1);
        drive("r7_after", 1'b0, 2'd0, 3'd0, 0, 0, 0, 5'd0, 5'd7, 5'd7);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(99) == 0) set_rst(1'b0);
            else if (!rst_n) set_rst(1'b1);
            a3 = ($urandom_range(15) == 0) ? 5'd0 : 5'($urandom);
            r1 = ($urandom_range(3) == 0) ? a3 : 5'($urandom);
            r2 = ($urandom_range(3) == 0) ? r1 : 5'($urandom);
            drive("rand", 1'($urandom), 2'($urandom), 3'($urandom), $urandom, $urandom,
                  $urandom, a3, r1, r2);
        end

        repeat (3) @(posedge clk);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
